spi_sync_fifo: RTL and testbench

Parametrised single-clock FIFO for the APB SPI lite TX and RX data paths, replacing the fixed 8-bit FIFO. It adds configurable width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags that the APB register block reads and clears.

---
 rtl/spi_sync_fifo.sv | 89 ++++++++
 tb/tb_spi_sync_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO for the SPI TX/RX paths; 1-cycle registered read, no fall-through.
// Rejected writes (full) and reads (empty) leave state intact and raise sticky error flags.
module spi_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              clr_err_i
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              wa;
  logic              ra;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign ra = r_en_i && !empty;
  assign wa = w_en_i && (!full || ra);

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && wa) begin
      mem[wp] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      data_o      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      // Flush drops contents only; data_o and error history survive.
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      overflow_o  <= overflow_o  && !clr_err_i;
      underflow_o <= underflow_o && !clr_err_i;
    end else begin
      if (wa) begin
        wp <= wp + AW'(1);
      end
      if (ra) begin
        data_o <= mem[rp];
        rp     <= rp + AW'(1);
      end
      if (wa && !ra) begin
        count <= count + CW'(1);
      end else if (ra && !wa) begin
        count <= count - CW'(1);
      end
      overflow_o  <= (overflow_o  && !clr_err_i) || (w_en_i && !wa);
      underflow_o <= (underflow_o && !clr_err_i) || (r_en_i && !ra);
    end
  end

  assign count_o        = count;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= CW'(AF_LEVEL));
  assign almost_empty_o = (count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_spi_sync_fifo.sv
// Scoreboard bench for spi_sync_fifo at DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
module tb_spi_sync_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              w_en = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              r_en = 1'b0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              full, empty, afull, aempty, ovf, udf;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .w_en_i(w_en), .data_i(data_in),
    .r_en_i(r_en), .data_o(data_out), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(udf), .clr_err_i(clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_ovf = 1'b0;
  logic              exp_udf = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of requests and advances the reference queue/flags alongside.
  task automatic do_cycle(input logic w, input logic [DATA_W-1:0] d, input logic r,
                          input logic fl, input logic clr);
    bit ra, wa;
    flush = fl; w_en = w; data_in = d; r_en = r; clr_err = clr;
    if (fl) begin
      q.delete();
      exp_ovf = exp_ovf && !clr;
      exp_udf = exp_udf && !clr;
    end else begin
      ra = r && (q.size() != 0);
      wa = w && ((q.size() < DEPTH) || ra);
      if (ra) exp_data = q.pop_front();
      if (wa) q.push_back(d);
      exp_ovf = (exp_ovf && !clr) || (w && !wa);
      exp_udf = (exp_udf && !clr) || (r && !ra);
    end
    step();
    flush = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; w_en = 1'b1; r_en = 1'b1; data_in = 8'hFF;
    step(); step();
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
    q.delete(); exp_data = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full: got %b/%b want 1/0", empty, full); end
    n_checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got ae=%b af=%b want 1/0", aempty, afull); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
    n_checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/0", ovf, udf); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_checks++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
      n_checks++; if (aempty !== (i + 1 <= AE)) begin n_fail++; $display("FAIL fill_aempty: count %0d got %b", i + 1, aempty); end
      n_checks++; if (afull !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_afull: count %0d got %b", i + 1, afull); end
      n_checks++; if (full !== (i + 1 == DEPTH) || empty !== 1'b0) begin n_fail++; $display("FAIL fill_full_empty: count %0d got %b/%b", i + 1, full, empty); end
    end
    do_cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b want 1", ovf); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count_after_ovf: got %0d want 16", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (data_out !== exp_data || exp_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data: got %h want %h", data_out, 8'(i)); end
    end
    n_checks++; if (empty !== 1'b1 || count !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got %b cnt %0d want 1/0", empty, count); end
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++; if (udf !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: got %b want 1", udf); end
    n_checks++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL drain_hold: got %h want 0f", data_out); end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] nxt = 8'h20;
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) begin
        if (b % 2 == 0) begin
          do_cycle(1'b1, nxt, 1'b0, 1'b0, 1'b0);
          nxt++;
        end else begin
          do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
          n_checks++; if (data_out !== exp_data) begin n_fail++; $display("FAIL wrap_data: got %h want %h", data_out, exp_data); end
        end
        n_checks++; if (count > 5'd5 || count !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count, q.size()); end
      end
    end
    n_checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %b/%b want 0/0", ovf, udf); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL simfull_count: got %0d want 16", count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL simfull_ovf: got %b want 0", ovf); end
    n_checks++; if (data_out !== 8'h30) begin n_fail++; $display("FAIL simfull_data: got %h want 30", data_out); end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (data_out !== exp_data) begin n_fail++; $display("FAIL simfull_drain: got %h want %h", data_out, exp_data); end
    end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL simfull_last: got %h want a5", data_out); end
  endtask

  task automatic test_simul_empty();
    do_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL simempty_count: got %0d want 1", count); end
    n_checks++; if (udf !== 1'b1) begin n_fail++; $display("FAIL simempty_udf: got %b want 1", udf); end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL simempty_data: got %h want a5", data_out); end
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    n_checks++; if (data_out !== 8'h77 || udf !== 1'b0) begin n_fail++; $display("FAIL simempty_read: got %h udf %b want 77/0", data_out, udf); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 7", count); end
    do_cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_state: got cnt %0d empty %b want 0/1", count, empty); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL flush_ovf: got %b want 0", ovf); end
    n_checks++; if (data_out !== 8'h77) begin n_fail++; $display("FAIL flush_data: got %h want 77", data_out); end
    do_cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++; if (data_out !== 8'h61 || data_out !== exp_data) begin n_fail++; $display("FAIL flush_after: got %h want 61", data_out); end
  endtask

  task automatic test_err_clear();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", ovf); end
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", ovf); end
    do_cycle(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1);
    n_checks++; if (ovf !== exp_ovf || ovf !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", ovf); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL err_count: got %0d want 16", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_flush();
    test_err_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
